// File: rtl/cnn_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_tile_sched
//  Description : Per-layer tile / channel-group scheduler for the sparse 4-bit
//                CNN accelerator (load -> compute per group, store per tile).
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_tile_sched #(
    parameter int Ifm_width = 10,
    parameter int TILE_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 layer_start,
    input  logic [Ifm_width-1:0] featuremap_W,
    input  logic [Ifm_width-1:0] featuremap_H,
    input  logic [Ifm_width-1:0] ifm_L,
    input  logic [Ifm_width-1:0] ifm_H,
    input  logic [Ifm_width-1:0] channels,
    input  logic                 load_ack,
    input  logic                 comp_done,
    input  logic                 store_ack,
    output logic [TILE_W-1:0]    tile_num,
    output logic [5:0]           tile_row,
    output logic [5:0]           tile_col,
    output logic [5:0]           ch_grp,
    output logic                 first_grp,
    output logic                 last_grp,
    output logic                 load_req,
    output logic                 comp_start,
    output logic                 store_req,
    output logic                 busy,
    output logic                 layer_done,
    output logic                 err
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_LOAD  = 3'd2;
    localparam logic [2:0] c_ST_COMP  = 3'd3;
    localparam logic [2:0] c_ST_STORE = 3'd4;
    localparam logic [2:0] c_ST_NEXT  = 3'd5;
    localparam logic [2:0] c_ST_DONE  = 3'd6;

    localparam logic [Ifm_width-1:0]   c_ONE       = Ifm_width'(1);
    localparam logic [2*Ifm_width-1:0] c_MAX_TILES = (2*Ifm_width)'(2**TILE_W);

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [Ifm_width-1:0]   r_fm_w;
    logic [Ifm_width-1:0]   r_fm_h;
    logic [Ifm_width-1:0]   r_ifm_l;
    logic [Ifm_width-1:0]   r_ifm_h;
    logic [Ifm_width-1:0]   r_cols;
    logic [Ifm_width-1:0]   r_rows;
    logic [Ifm_width:0]     r_acc_w;
    logic [Ifm_width:0]     r_acc_h;
    logic [5:0]             r_groups;
    logic [5:0]             r_ch_grp;
    logic [5:0]             r_tile_row;
    logic [5:0]             r_tile_col;
    logic [TILE_W-1:0]      r_tile_num;
    logic                   r_comp_first;
    logic                   r_err;

    logic                   w_cfg_bad;
    logic                   w_w_done;
    logic                   w_h_done;
    logic                   w_setup_done;
    logic [2*Ifm_width-1:0] w_tiles;
    logic                   w_too_many;
    logic                   w_last_grp;
    logic                   w_last_col;
    logic                   w_last_tile;
    logic                   w_active;

    assign w_cfg_bad    = (ifm_L == '0) || (ifm_H == '0) || (channels == '0) ||
                          (channels[3:0] != 4'd0);
    assign w_w_done     = r_acc_w >= {1'b0, r_fm_w};
    assign w_h_done     = r_acc_h >= {1'b0, r_fm_h};
    assign w_setup_done = w_w_done && w_h_done;
    assign w_tiles      = (2*Ifm_width)'(r_cols) * (2*Ifm_width)'(r_rows);
    assign w_too_many   = w_tiles > c_MAX_TILES;
    assign w_last_grp   = r_ch_grp == (r_groups - 6'd1);
    assign w_last_col   = r_tile_col == 6'(r_cols - c_ONE);
    assign w_last_tile  = w_last_col && (r_tile_row == 6'(r_rows - c_ONE));
    assign w_active     = (r_state == c_ST_SETUP) || (r_state == c_ST_LOAD) ||
                          (r_state == c_ST_COMP)  || (r_state == c_ST_STORE) ||
                          (r_state == c_ST_NEXT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (layer_start) begin
                    w_next = w_cfg_bad ? c_ST_DONE : c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                if (w_setup_done) begin
                    w_next = w_too_many ? c_ST_DONE : c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (load_ack) begin
                    w_next = c_ST_COMP;
                end
            end
            c_ST_COMP: begin
                // A done pulse coincident with our own start pulse cannot belong to this group.
                if (comp_done && !r_comp_first) begin
                    w_next = w_last_grp ? c_ST_STORE : c_ST_LOAD;
                end
            end
            c_ST_STORE: begin
                if (store_ack) begin
                    w_next = c_ST_NEXT;
                end
            end
            c_ST_NEXT: begin
                w_next = w_last_tile ? c_ST_DONE : c_ST_LOAD;
            end
            c_ST_DONE: begin
                w_next = c_ST_IDLE;
            end
            default: begin
                w_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fm_w       <= '0;
            r_fm_h       <= '0;
            r_ifm_l      <= '0;
            r_ifm_h      <= '0;
            r_cols       <= '0;
            r_rows       <= '0;
            r_acc_w      <= '0;
            r_acc_h      <= '0;
            r_groups     <= '0;
            r_ch_grp     <= '0;
            r_tile_row   <= '0;
            r_tile_col   <= '0;
            r_tile_num   <= '0;
            r_comp_first <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_comp_first <= (w_next == c_ST_COMP) && (r_state != c_ST_COMP);
            case (r_state)
                c_ST_IDLE: begin
                    if (layer_start) begin
                        r_fm_w   <= featuremap_W;
                        r_fm_h   <= featuremap_H;
                        r_ifm_l  <= ifm_L;
                        r_ifm_h  <= ifm_H;
                        r_groups <= 6'(channels >> 4);
                        r_acc_w  <= {1'b0, ifm_L};
                        r_acc_h  <= {1'b0, ifm_H};
                        r_cols   <= c_ONE;
                        r_rows   <= c_ONE;
                        r_err    <= w_cfg_bad;
                    end
                end
                c_ST_SETUP: begin
                    // Repeated addition replaces ceil(W/L) and ceil(H/Hh) dividers.
                    if (!w_setup_done) begin
                        if (!w_w_done) begin
                            r_acc_w <= r_acc_w + {1'b0, r_ifm_l};
                            r_cols  <= r_cols + c_ONE;
                        end
                        if (!w_h_done) begin
                            r_acc_h <= r_acc_h + {1'b0, r_ifm_h};
                            r_rows  <= r_rows + c_ONE;
                        end
                    end else if (w_too_many) begin
                        r_err <= 1'b1;
                    end else begin
                        r_ch_grp   <= '0;
                        r_tile_row <= '0;
                        r_tile_col <= '0;
                        r_tile_num <= '0;
                    end
                end
                c_ST_COMP: begin
                    if (comp_done && !r_comp_first && !w_last_grp) begin
                        r_ch_grp <= r_ch_grp + 6'd1;
                    end
                end
                c_ST_NEXT: begin
                    r_ch_grp <= '0;
                    if (!w_last_tile) begin
                        if (w_last_col) begin
                            r_tile_col <= '0;
                            r_tile_row <= r_tile_row + 6'd1;
                        end else begin
                            r_tile_col <= r_tile_col + 6'd1;
                        end
                        r_tile_num <= r_tile_num + TILE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tile_num   = r_tile_num;
    assign tile_row   = r_tile_row;
    assign tile_col   = r_tile_col;
    assign ch_grp     = r_ch_grp;
    assign first_grp  = w_active && (r_ch_grp == 6'd0);
    assign last_grp   = w_active && w_last_grp;
    assign load_req   = (r_state == c_ST_LOAD);
    assign comp_start = (r_state == c_ST_COMP) && r_comp_first;
    assign store_req  = (r_state == c_ST_STORE);
    assign busy       = w_active;
    assign layer_done = (r_state == c_ST_DONE);
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cnn_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnn_tile_sched
//  Description : Scoreboard bench for cnn_tile_sched with random handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_tile_sched;

    localparam int IW = 10;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          layer_start;
    logic [IW-1:0] featuremap_W, featuremap_H, ifm_L, ifm_H, channels;
    logic          load_ack, comp_done, store_ack;
    logic [TW-1:0] tile_num;
    logic [5:0]    tile_row, tile_col, ch_grp;
    logic          first_grp, last_grp, load_req, comp_start, store_req;
    logic          busy, layer_done, err;

    cnn_tile_sched #(.Ifm_width(IW), .TILE_W(TW)) dut (
        .clk(clk), .rst(rst), .layer_start(layer_start),
        .featuremap_W(featuremap_W), .featuremap_H(featuremap_H),
        .ifm_L(ifm_L), .ifm_H(ifm_H), .channels(channels),
        .load_ack(load_ack), .comp_done(comp_done), .store_ack(store_ack),
        .tile_num(tile_num), .tile_row(tile_row), .tile_col(tile_col),
        .ch_grp(ch_grp), .first_grp(first_grp), .last_grp(last_grp),
        .load_req(load_req), .comp_start(comp_start), .store_req(store_req),
        .busy(busy), .layer_done(layer_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 load accepted, 1 compute start, 2 store accepted, 3 layer done
        int tn;
        int row;
        int col;
        int grp;
        bit first;
        bit last;
        bit err;
    } ev_t;

    ev_t sq[$];
    int  checks = 0;
    int  errors = 0;
    int  ld_fix = -1;

    function automatic logic [47:0] pk(int k, int tn, int row, int col, int grp, bit f, bit l, bit e);
        return {8'(k), 8'(tn), 8'(row), 8'(col), 8'(grp), 5'd0, f, l, e};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(int k, int tn, int row, int col, int grp, bit f, bit l, bit e);
        ev_t x;
        x.kind = k; x.tn = tn; x.row = row; x.col = col; x.grp = grp;
        x.first = f; x.last = l; x.err = e;
        sq.push_back(x);
    endtask

    task automatic see(int k);
        ev_t e;
        logic [47:0] a, x;
        a = pk(k, (k < 3) ? int'(tile_num) : 0, (k < 3) ? int'(tile_row) : 0,
               (k < 3) ? int'(tile_col) : 0, (k < 2) ? int'(ch_grp) : 0,
               (k == 1) ? first_grp : 1'b0, (k == 1) ? last_grp : 1'b0,
               (k == 3) ? err : 1'b0);
        checks++;
        if (sq.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected: got kind %0d expected none", k);
        end else begin
            e = sq.pop_front();
            x = pk(e.kind, e.tn, e.row, e.col, e.grp, e.first, e.last, e.err);
            if (a !== x) begin
                errors++;
                $display("FAIL event_kind%0d: got %h expected %h", k, a, x);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (load_req && load_ack)   see(0);
            if (comp_start)             see(1);
            if (store_req && store_ack) see(2);
            if (layer_done) begin
                see(3);
                chk("done_busy_low", int'(busy), 0);
            end
        end
    end

    // Reference: schedule derived from ceil() tile counts and nested tile/group loops.
    task automatic model(int w, int h, int l, int hh, int ch,
                         output int exp_lat, output bit exp_err, output bit early);
        int cols, rows, g, r, c;
        early = 0; exp_err = 0;
        if (l == 0 || hh == 0 || ch == 0 || (ch % 16) != 0) begin
            early = 1; exp_err = 1; exp_lat = 1;
            push(3, 0, 0, 0, 0, 0, 0, 1);
            return;
        end
        cols = (w + l - 1) / l;  if (cols < 1) cols = 1;
        rows = (h + hh - 1) / hh; if (rows < 1) rows = 1;
        exp_lat = 1 + ((cols > rows) ? cols : rows);
        if (cols * rows > (1 << TW)) begin
            exp_err = 1;
            push(3, 0, 0, 0, 0, 0, 0, 1);
            return;
        end
        g = ch / 16;
        for (int t = 0; t < cols * rows; t++) begin
            r = t / cols; c = t % cols;
            for (int k = 0; k < g; k++) begin
                push(0, t, r, c, k, 0, 0, 0);
                push(1, t, r, c, k, k == 0, k == g - 1, 0);
            end
            push(2, t, r, c, 0, 0, 0, 0);
        end
        push(3, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int outs();
        return int'({tile_num, tile_row, tile_col, ch_grp, first_grp, last_grp, load_req,
                     comp_start, store_req, busy, layer_done, err});
    endfunction

    task automatic scramble();
        featuremap_W = 10'($urandom); featuremap_H = 10'($urandom);
        ifm_L = 10'($urandom); ifm_H = 10'($urandom); channels = 10'($urandom);
    endtask

    task automatic run_layer(int w, int h, int l, int hh, int ch, bit do_rst);
        int exp_lat, lat, cyc;
        bit exp_err, early, first_seen, hit;
        model(w, h, l, hh, ch, exp_lat, exp_err, early);
        featuremap_W = 10'(w); featuremap_H = 10'(h);
        ifm_L = 10'(l); ifm_H = 10'(hh); channels = 10'(ch);
        layer_start = 1'b1;
        @(posedge clk); #1;
        layer_start = 1'b0;
        scramble();
        lat = 1; cyc = 0; first_seen = 0; hit = 0;
        if (!early) chk("busy_rise", int'(busy), 1);
        while (!layer_done && cyc < 20000) begin
            if (!first_seen && load_req) begin
                first_seen = 1;
                chk("first_load_latency", lat, exp_lat);
            end
            if (do_rst && comp_start && tile_num == 3) begin
                hit = 1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("rst_mid_outputs", outs(), 0);
                sq.delete();
                break;
            end
            layer_start = (cyc == 6) && busy;
            if (layer_start) scramble();
            @(posedge clk); #1;
            layer_start = 1'b0;
            cyc++; lat++;
        end
        if (do_rst) begin
            chk("rst_hit_tile3", int'(hit), 1);
            return;
        end
        if (cyc >= 20000) begin
            chk("layer_done_timeout", 0, 1);
            sq.delete();
            rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
            return;
        end
        if (exp_err) chk("err_done_latency", lat, exp_lat);
        @(negedge clk); #1;
        chk("queue_drained", sq.size(), 0);
        @(posedge clk); #1;
        chk("err_sticky", int'(err), int'(exp_err));
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        int w, prev;
        load_ack = 1'b0; w = 0; prev = 0;
        forever begin
            @(posedge clk); #1;
            load_ack = 1'b0;
            if (load_req && !prev) w = (ld_fix >= 0) ? ld_fix : int'($urandom_range(0, 3));
            prev = int'(load_req);
            if (load_req) begin
                if (w == 0) load_ack = 1'b1;
                else w--;
            end else if ($urandom_range(0, 9) == 0) begin
                load_ack = 1'b1;
            end
        end
    end

    initial begin
        int w, prev;
        store_ack = 1'b0; w = 0; prev = 0;
        forever begin
            @(posedge clk); #1;
            store_ack = 1'b0;
            if (store_req && !prev) w = $urandom_range(0, 3);
            prev = int'(store_req);
            if (store_req) begin
                if (w == 0) store_ack = 1'b1;
                else w--;
            end else if ($urandom_range(0, 9) == 0) begin
                store_ack = 1'b1;
            end
        end
    end

    initial begin
        int cnt;
        bit pend;
        comp_done = 1'b0; cnt = 0; pend = 0;
        forever begin
            @(posedge clk); #1;
            comp_done = 1'b0;
            if (!busy) pend = 0;
            if (comp_start) begin
                pend = 1; cnt = $urandom_range(1, 4);
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    comp_done = 1'b1; pend = 0;
                end
            end else if (load_req && $urandom_range(0, 5) == 0) begin
                comp_done = 1'b1;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int w, h, l, hh, ch;
        rst = 1'b1; layer_start = 1'b0;
        featuremap_W = '0; featuremap_H = '0; ifm_L = '0; ifm_H = '0; channels = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outputs", outs(), 0);

        run_layer(32, 32, 32, 32, 16, 0);
        run_layer(224, 224, 112, 28, 64, 0);
        run_layer(30, 8, 16, 8, 32, 0);
        run_layer(32, 32, 0, 32, 16, 0);
        run_layer(32, 32, 32, 32, 24, 0);
        run_layer(224, 224, 28, 28, 16, 0);
        ld_fix = 5;
        run_layer(30, 8, 16, 8, 32, 0);
        ld_fix = -1;
        run_layer(224, 224, 112, 28, 64, 1);
        run_layer(32, 32, 32, 32, 16, 0);

        for (int i = 0; i < 14; i++) begin
            w  = $urandom_range(1, 96);
            h  = $urandom_range(1, 96);
            l  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 48));
            hh = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 48));
            ch = ($urandom_range(0, 7) == 0) ? 16 * int'($urandom_range(0, 3)) + 8
                                             : 16 * int'($urandom_range(1, 3));
            run_layer(w, h, l, hh, ch, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
